// File: rtl/muldiv_seq.sv
// muldiv_seq: sequential MIPS-style multiply/divide unit that owns HI/LO.
// Division is restoring radix-2, one quotient bit per cycle, with the sign
// applied in a separate FIX cycle. Multiply is single-cycle by default.
// Optional build macro: MULDIV_ITER_MUL_EN selects a 32-cycle shift-add
// multiplier that reuses the divider's 64-bit {rem,quo} register pair.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        validE,
    input  logic [2:0]  opE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        flushE,
    output logic        stall_muldivE,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a, r_b, r_srca, r_rem, r_quo, r_hi, r_lo;
    logic        r_neg_q, r_neg_r, r_is_div;

    logic        w_accept, w_sgn, w_is_mul, w_ge;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_pr;
    logic [63:0] w_fix;

    // Signed ops work on magnitudes; sign is re-applied at the end
    assign w_sgn    = (opE == 3'd1) || (opE == 3'd3);
    assign w_is_mul = (opE == 3'd1) || (opE == 3'd2);
    assign w_mag_a  = (w_sgn && srcaE[31]) ? -srcaE : srcaE;
    assign w_mag_b  = (w_sgn && srcbE[31]) ? -srcbE : srcbE;
    assign w_accept = (r_state == S_IDLE) && validE && !flushE &&
                      (opE >= 3'd1) && (opE <= 3'd4);

    assign stall_muldivE = w_accept || (r_state == S_MUL) ||
                           (r_state == S_DIV) || (r_state == S_FIX);
    assign busy = (r_state != S_IDLE);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // One restoring-division step: shift in next dividend bit, try subtract
    assign w_pr = {r_rem, r_quo[31]};
    assign w_ge = (w_pr >= {1'b0, r_b});

    // Final sign fix-up; divide-by-zero bypasses it and returns fixed values
    always_comb begin
        w_fix = {r_rem, r_quo};
        if (r_is_div) begin
            if (r_b == 32'd0)
                w_fix = {r_srca, 32'hFFFF_FFFF};
            else
                w_fix = {(r_neg_r ? -r_rem : r_rem), (r_neg_q ? -r_quo : r_quo)};
        end else if (r_neg_q) begin
            w_fix = -{r_rem, r_quo};
        end
    end

`ifdef MULDIV_ITER_MUL_EN
    logic [32:0] w_sum;
    // Shift-add step: add multiplicand when multiplier LSB is set, shift right
    assign w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_a} : 33'd0);
`else
    logic [63:0] w_prod, w_mulres;
    // Single-cycle product with sign applied in the same cycle
    assign w_prod   = {32'd0, r_a} * {32'd0, r_b};
    assign w_mulres = r_neg_q ? -w_prod : w_prod;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; flush abandons any in-flight operation
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_is_mul ? S_MUL : S_DIV;
`ifdef MULDIV_ITER_MUL_EN
            S_MUL:  if (flushE) w_next = S_IDLE;
                    else if (r_cnt == 5'd31) w_next = S_FIX;
`else
            S_MUL:  w_next = flushE ? S_IDLE : S_DONE;
`endif
            S_DIV:  if (flushE) w_next = S_IDLE;
                    else if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:  w_next = flushE ? S_IDLE : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and HI/LO writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0; r_a <= '0; r_b <= '0; r_srca <= '0;
            r_rem <= '0; r_quo <= '0; r_hi <= '0; r_lo <= '0;
            r_neg_q <= 1'b0; r_neg_r <= 1'b0; r_is_div <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a      <= w_mag_a;
                r_b      <= w_mag_b;
                r_srca   <= srcaE;
                r_neg_q  <= w_sgn && (srcaE[31] ^ srcbE[31]);
                r_neg_r  <= w_sgn && srcaE[31];
                r_is_div <= !w_is_mul;
                r_cnt    <= '0;
                r_rem    <= '0;
                // quo holds the dividend for divide, the multiplier for multiply
                r_quo    <= w_is_mul ? w_mag_b : w_mag_a;
            end else if (r_state == S_DIV) begin
                r_rem <= w_ge ? 32'(w_pr - {1'b0, r_b}) : w_pr[31:0];
                r_quo <= {r_quo[30:0], w_ge};
                r_cnt <= r_cnt + 5'd1;
            end
`ifdef MULDIV_ITER_MUL_EN
            else if (r_state == S_MUL) begin
                r_rem <= w_sum[32:1];
                r_quo <= {w_sum[0], r_quo[31:1]};
                r_cnt <= r_cnt + 5'd1;
            end
`else
            if (r_state == S_MUL && !flushE) {r_hi, r_lo} <= w_mulres;
`endif
            if (r_state == S_FIX && !flushE) {r_hi, r_lo} <= w_fix;
            if (r_state == S_IDLE && validE && opE == 3'd5) r_hi <= srcaE;
            if (r_state == S_IDLE && validE && opE == 3'd6) r_lo <= srcaE;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random
// MULT/MULTU/DIV/DIVU operations against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst, validE, flushE;
    logic [2:0]  opE;
    logic [31:0] srcaE, srcbE;
    logic        stall_muldivE, busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 34;
`else
    localparam int MUL_LAT = 2;
`endif
    localparam int DIV_LAT = 34;

    muldiv_seq dut (
        .clk(clk), .rst(rst), .validE(validE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .flushE(flushE),
        .stall_muldivE(stall_muldivE), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {HI,LO} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = {32'd0, a} * {32'd0, b};
            3'd3, 3'd4: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else if (op == 3'd3) begin
                    q = sa / sb; m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Issue one op, count stall cycles, check result in the DONE cycle
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        validE = 1'b1; opE = op; srcaE = a; srcbE = b;
        #1;
        n = 0;
        while (stall_muldivE && n < 100) begin
            n++;
            @(negedge clk);
            validE = 1'b0; opE = 3'd0;
            #1;
        end
        check({tag, " latency"}, 64'(n), 64'((op <= 3'd2) ? MUL_LAT : DIV_LAT));
        check({tag, " done busy"}, 64'(busy), 64'd1);
        check({tag, " hilo"}, {hi, lo}, exp);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        validE = 1'b0; opE = 3'd0;
        #1;
        check({tag, " idle busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, lo_keep;
        rst = 1'b1; validE = 1'b0; flushE = 1'b0; opE = 3'd0; srcaE = '0; srcbE = '0;
        #12;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(stall_muldivE), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("divu 100/7", 3'd4, 32'd100, 32'd7);   idle_check("divu 100/7");
        run_op("div -7/2", 3'd3, 32'hFFFF_FFF9, 32'd2); idle_check("div -7/2");
        run_op("div min/-1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle_check("div min/-1");
        run_op("divu 5/0", 3'd4, 32'd5, 32'd0);       idle_check("divu 5/0");
        run_op("div -5/0", 3'd3, 32'hFFFF_FFFB, 32'd0); idle_check("div -5/0");
        run_op("mult -3*4", 3'd1, 32'hFFFF_FFFD, 32'd4); idle_check("mult -3*4");
        run_op("multu ff*2", 3'd2, 32'hFFFF_FFFF, 32'd2); idle_check("multu ff*2");

        // MTLO in IDLE: next-edge write, no stall
        @(negedge clk);
        validE = 1'b1; opE = 3'd6; srcaE = 32'h1234_5678; #1;
        check("mtlo stall", 64'(stall_muldivE), 64'd0);
        @(negedge clk); validE = 1'b0; opE = 3'd0; #1;
        check("mtlo lo", 64'(lo), 64'h1234_5678);
        check("mtlo busy", 64'(busy), 64'd0);

        // MTLO presented during DONE is ignored
        run_op("divu 9/4", 3'd4, 32'd9, 32'd4);
        validE = 1'b1; opE = 3'd6; srcaE = 32'hDEAD_BEEF; #1;
        check("done mtlo stall", 64'(stall_muldivE), 64'd0);
        @(negedge clk); validE = 1'b0; opE = 3'd0; #1;
        check("done mtlo lo", 64'(lo), 64'd2);
        check("done mtlo busy", 64'(busy), 64'd0);

        // Flush at T+10 of a DIV leaves HI untouched
        @(negedge clk); validE = 1'b1; opE = 3'd5; srcaE = 32'hAA;
        @(negedge clk); validE = 1'b1; opE = 3'd3; srcaE = 32'd1000; srcbE = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); validE = 1'b0; opE = 3'd0;
        end
        flushE = 1'b1;
        @(negedge clk); flushE = 1'b0; #1;
        check("flush stall", 64'(stall_muldivE), 64'd0);
        check("flush busy", 64'(busy), 64'd0);
        check("flush hi", 64'(hi), 64'hAA);

        // Flush in the accept cycle blocks the accept
        @(negedge clk); validE = 1'b1; opE = 3'd4; srcaE = 32'd8; srcbE = 32'd2; flushE = 1'b1;
        @(negedge clk); validE = 1'b0; opE = 3'd0; flushE = 1'b0; #1;
        check("flush accept busy", 64'(busy), 64'd0);

        // Random ops against the model
        for (int i = 0; i < 16; i++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 20));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d %h %h", i, op, a, b), op, a, b);
            idle_check("rand");
        end

        // Reset during MUL abandons the op and clears everything
        run_op("multu pre", 3'd2, 32'h1234_5678, 32'h9ABC_DEF0); idle_check("multu pre");
        lo_keep = lo;
        @(negedge clk); validE = 1'b1; opE = 3'd1; srcaE = 32'd7; srcbE = 32'd9;
        @(negedge clk); validE = 1'b0; opE = 3'd0; rst = 1'b1; #1;
        check("rst mid hi", 64'(hi), 64'd0);
        check("rst mid lo", 64'(lo), 64'd0);
        check("rst mid stall", 64'(stall_muldivE), 64'd0);
        check("rst mid busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #1;
        check("post rst lo", 64'(lo), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
